// File: rtl/ppm_decoder_if.sv
// rtl/ppm_decoder_if.sv - decoded-frame output bundle of the PPM decoder
interface ppm_decoder_if #(
    parameter int FRAME_BITS = 8
);
    logic [FRAME_BITS-1:0] data_out;
    logic                  data_valid;
    logic                  err_none;
    logic                  err_multi;

    // Decoder side drives the frame results
    modport master (
        output data_out,
        output data_valid,
        output err_none,
        output err_multi
    );

    // Consumer side (register block / loopback checker)
    modport slave (
        input data_out,
        input data_valid,
        input err_none,
        input err_multi
    );
endinterface

// File: rtl/ppm_decoder.sv
// rtl/ppm_decoder.sv - one-pulse-per-frame PPM receiver with frame-sync alignment
module ppm_decoder #(
    parameter int FRAME_BITS  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PIPE_DELAY  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ppm_in,
    input  logic               frame_sync,
    ppm_decoder_if.master      out_if,
    output logic               locked,
    output logic               sync_slip
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [FRAME_BITS-1:0] ADJ_FIRST = '0;
    localparam logic [FRAME_BITS-1:0] ADJ_LAST  = '1;
    localparam logic [FRAME_BITS-1:0] PIPE_OFS  = FRAME_BITS'(PIPE_DELAY);
    localparam logic [FRAME_BITS-1:0] CNT_ONE   = FRAME_BITS'(1);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    last_q, last_d;
    logic [1:0]              pulse_cnt_q, pulse_cnt_d;
    logic [FRAME_BITS-1:0]   pos_q, pos_d;
    logic [FRAME_BITS-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    err_none_q, err_none_d;
    logic                    err_multi_q, err_multi_d;
    logic                    locked_q, locked_d;
    logic                    sync_slip_q, sync_slip_d;

    logic                    pulse_event;
    logic [FRAME_BITS-1:0]   adj;
    logic                    slip;
    logic                    accumulate;
    logic                    frame_end;
    logic [1:0]              acc_cnt;
    logic [FRAME_BITS-1:0]   acc_pos;

    // Next-state logic: synchronizer, frame counter, alignment FSM, accumulation and frame results
    always_comb begin
        // Rising edge at the synchronizer output; a stuck-high input yields one event
        pulse_event = sync_q[SYNC_STAGES-1] & ~last_q;
        // Encoder position the event in this cycle corresponds to
        adj         = cnt_q - PIPE_OFS;

        sync_d = {sync_q[SYNC_STAGES-2:0], ppm_in};
        last_d = sync_q[SYNC_STAGES-1];

        // frame_sync marks encoder counter 0, so our counter becomes 1 next cycle
        cnt_d = frame_sync ? CNT_ONE : cnt_q + CNT_ONE;

        // A sync that lands where the counter is already 0 is in phase and changes nothing
        slip = frame_sync && (cnt_q != '0) && (state_q != ST_UNLOCKED);

        // The ARMING cycle with adj==0 is the first cycle of the first locked frame
        accumulate = !slip && ((state_q == ST_LOCKED) ||
                               ((state_q == ST_ARMING) && (adj == ADJ_FIRST)));
        frame_end  = !slip && (state_q == ST_LOCKED) && (adj == ADJ_LAST);

        // Fold this cycle's event into the running count (saturating at 2) and first position
        acc_cnt = pulse_cnt_q;
        acc_pos = pos_q;
        if (accumulate && pulse_event) begin
            if (pulse_cnt_q == 2'd0) begin
                acc_pos = adj;
            end
            if (pulse_cnt_q != 2'd2) begin
                acc_cnt = pulse_cnt_q + 2'd1;
            end
        end

        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        pos_d        = pos_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        err_none_d   = 1'b0;
        err_multi_d  = 1'b0;
        sync_slip_d  = slip;

        case (state_q)
            ST_UNLOCKED: begin
                if (frame_sync) begin
                    state_d     = ST_ARMING;
                    pulse_cnt_d = 2'd0;
                end
            end
            ST_ARMING: begin
                if (slip) begin
                    pulse_cnt_d = 2'd0;
                end else if (adj == ADJ_FIRST) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (slip) begin
                    state_d     = ST_ARMING;
                    pulse_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d     = ST_UNLOCKED;
                pulse_cnt_d = 2'd0;
            end
        endcase

        if (accumulate) begin
            pulse_cnt_d = acc_cnt;
            pos_d       = acc_pos;
        end

        // Publish the frame and restart accumulation with no gap to the next frame
        if (frame_end) begin
            data_valid_d = 1'b1;
            err_none_d   = (acc_cnt == 2'd0);
            err_multi_d  = (acc_cnt == 2'd2);
            if (acc_cnt != 2'd0) begin
                data_out_d = acc_pos;
            end
            pulse_cnt_d = 2'd0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and registered outputs; reset wins over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_UNLOCKED;
            cnt_q        <= '0;
            sync_q       <= '0;
            last_q       <= 1'b0;
            pulse_cnt_q  <= 2'd0;
            pos_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_none_q   <= 1'b0;
            err_multi_q  <= 1'b0;
            locked_q     <= 1'b0;
            sync_slip_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            last_q       <= last_d;
            pulse_cnt_q  <= pulse_cnt_d;
            pos_q        <= pos_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_none_q   <= err_none_d;
            err_multi_q  <= err_multi_d;
            locked_q     <= locked_d;
            sync_slip_q  <= sync_slip_d;
        end
    end

    assign out_if.data_out   = data_out_q;
    assign out_if.data_valid = data_valid_q;
    assign out_if.err_none   = err_none_q;
    assign out_if.err_multi  = err_multi_q;
    assign locked            = locked_q;
    assign sync_slip         = sync_slip_q;

endmodule
